uart_ctrl: RTL

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_ctrl_pkg.sv | 21 ++
 rtl/uart_ctrl_if.sv | 26 ++
 rtl/uart_fifo.sv | 72 +++++++
 rtl/uart_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller: FSM state encoding, RX FIFO word
// layout and the parity helper used by both serial directions.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // RX FIFO word is {perr, ferr, data}; offsets are relative to bit DBIT
   localparam int ERR_FERR_OFS = 0;
   localparam int ERR_PERR_OFS = 1;

   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// Host-side bus of the UART controller: FIFO push/pop handshakes, RX head word
// with its error flags, and the sticky overrun flag.
interface uart_ctrl_if #(parameter int DBIT = 8);

   logic            wr_uart;
   logic [DBIT-1:0] w_data;
   logic            rd_uart;
   logic            clr_ovr;
   logic            tx_full;
   logic            rx_empty;
   logic [DBIT-1:0] r_data;
   logic            rx_perr;
   logic            rx_ferr;
   logic            rx_ovr;

   modport master (
      output wr_uart, w_data, rd_uart, clr_ovr,
      input  tx_full, rx_empty, r_data, rx_perr, rx_ferr, rx_ovr
   );

   modport slave (
      input  wr_uart, w_data, rd_uart, clr_ovr,
      output tx_full, rx_empty, r_data, rx_perr, rx_ferr, rx_ovr
   );

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO of 2**W words of B bits with registered
// full/empty flags; a push into a full FIFO only succeeds alongside a pop.
module uart_fifo #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic         rd,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         full,
   output logic         empty
);

   localparam int DEPTH = 1 << W;

   logic [B-1:0] mem_r [DEPTH];
   logic [W-1:0] wptr_r;
   logic [W-1:0] rptr_r;
   logic         full_r;
   logic         empty_r;
   logic [W-1:0] wptr_succ_s;
   logic [W-1:0] rptr_succ_s;
   logic         wr_en_s;
   logic         rd_en_s;

   // Qualify requests against the current flags and form successor pointers
   always_comb begin
      wr_en_s     = wr & (~full_r | rd);
      rd_en_s     = rd & ~empty_r;
      wptr_succ_s = wptr_r + W'(1);
      rptr_succ_s = rptr_r + W'(1);
   end

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wptr_r] <= w_data;
      end
   end

   // Pointer and flag update
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else if (wr_en_s && rd_en_s) begin
         wptr_r <= wptr_succ_s;
         rptr_r <= rptr_succ_s;
      end else if (wr_en_s) begin
         wptr_r  <= wptr_succ_s;
         empty_r <= 1'b0;
         full_r  <= (wptr_succ_s == rptr_r);
      end else if (rd_en_s) begin
         rptr_r  <= rptr_succ_s;
         full_r  <= 1'b0;
         empty_r <= (rptr_succ_s == wptr_r);
      end else begin
         wptr_r <= wptr_r;
         rptr_r <= rptr_r;
      end
   end

   assign r_data = mem_r[rptr_r];
   assign full   = full_r;
   assign empty  = empty_r;

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: runtime baud tick generator, oversampling RX and TX engines
// with optional parity, and a FIFO in each direction toward the host bus.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int FIFO_W  = 2,
   parameter int DVSR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              rx,
   output logic              tx,
   output logic              tick,
   uart_ctrl_if.slave        bus
);

   localparam int S_W = (SB_TICK > 2) ? $clog2(SB_TICK) : 1;
   localparam int N_W = $clog2(DBIT);
   localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);
   localparam logic [S_W-1:0] S_HALF = S_W'(SB_TICK / 2 - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
   localparam int RXW = DBIT + 2;

   logic [DVSR_W-1:0] cnt_r;
   logic              tick_r;
   logic              rx_meta_r;
   logic              rx_sync_r;

   uart_state_e       rx_state_r;
   logic [S_W-1:0]    rx_s_r;
   logic [N_W-1:0]    rx_n_r;
   logic [DBIT-1:0]   rx_b_r;
   logic              rx_pen_r;
   logic              rx_podd_r;
   logic              rx_perr_r;
   logic              rx_ovr_r;
   logic              rx_done_s;
   logic [RXW-1:0]    rx_word_s;
   logic [RXW-1:0]    rx_head_s;
   logic              rx_full_s;
   logic              rx_empty_s;

   uart_state_e       tx_state_r;
   logic [S_W-1:0]    tx_s_r;
   logic [N_W-1:0]    tx_n_r;
   logic [DBIT-1:0]   tx_b_r;
   logic              tx_pen_r;
   logic              tx_par_r;
   logic              tx_r;
   logic              tx_pop_s;
   logic [DBIT-1:0]   tx_head_s;
   logic              tx_full_s;
   logic              tx_empty_s;

   // Baud tick: one pulse every dvsr clocks; a count stranded above a new dvsr restarts silently
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (dvsr < DVSR_W'(2)) begin
         cnt_r  <= '0;
         tick_r <= 1'b1;
      end else if (cnt_r >= dvsr) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (cnt_r == dvsr - DVSR_W'(1)) begin
         cnt_r  <= '0;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + DVSR_W'(1);
         tick_r <= 1'b0;
      end
   end

   // Two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // RX engine: mid-bit sampling, parity check on the assembled byte
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r <= ST_IDLE;
         rx_s_r     <= '0;
         rx_n_r     <= '0;
         rx_b_r     <= '0;
         rx_pen_r   <= 1'b0;
         rx_podd_r  <= 1'b0;
         rx_perr_r  <= 1'b0;
      end else begin
         case (rx_state_r)
            ST_IDLE: begin
               if (!rx_sync_r) begin
                  rx_state_r <= ST_START;
                  rx_s_r     <= '0;
                  rx_pen_r   <= parity_en;
                  rx_podd_r  <= parity_odd;
                  rx_perr_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (tick_r) begin
                  if (rx_s_r == S_HALF) begin
                     rx_s_r     <= '0;
                     rx_n_r     <= '0;
                     rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                  end else begin
                     rx_s_r <= rx_s_r + S_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick_r) begin
                  if (rx_s_r == S_LAST) begin
                     rx_s_r <= '0;
                     rx_b_r <= {rx_sync_r, rx_b_r[DBIT-1:1]};
                     if (rx_n_r == N_LAST) begin
                        rx_state_r <= rx_pen_r ? ST_PARITY : ST_STOP;
                     end else begin
                        rx_n_r <= rx_n_r + N_W'(1);
                     end
                  end else begin
                     rx_s_r <= rx_s_r + S_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick_r) begin
                  if (rx_s_r == S_LAST) begin
                     rx_s_r     <= '0;
                     rx_perr_r  <= rx_sync_r ^ parity_bit(9'(rx_b_r), rx_podd_r);
                     rx_state_r <= ST_STOP;
                  end else begin
                     rx_s_r <= rx_s_r + S_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick_r) begin
                  if (rx_s_r == S_LAST) begin
                     rx_s_r     <= '0;
                     rx_state_r <= ST_IDLE;
                  end else begin
                     rx_s_r <= rx_s_r + S_W'(1);
                  end
               end
            end
            default: begin
               rx_state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Stop-bit sample completes the frame and pushes it with its error flags
   always_comb begin
      rx_word_s                      = '0;
      rx_done_s                      = (rx_state_r == ST_STOP) && tick_r && (rx_s_r == S_LAST);
      rx_word_s[DBIT-1:0]            = rx_b_r;
      rx_word_s[DBIT + ERR_FERR_OFS] = ~rx_sync_r;
      rx_word_s[DBIT + ERR_PERR_OFS] = rx_perr_r;
   end

   // Sticky overrun; a new overrun outranks a same-cycle clear
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ovr_r <= 1'b0;
      end else if (rx_done_s && rx_full_s && !bus.rd_uart) begin
         rx_ovr_r <= 1'b1;
      end else if (bus.clr_ovr) begin
         rx_ovr_r <= 1'b0;
      end else begin
         rx_ovr_r <= rx_ovr_r;
      end
   end

   // TX pops its FIFO in the same cycle it loads the shifter
   always_comb begin
      tx_pop_s = (tx_state_r == ST_IDLE) && !tx_empty_s;
   end

   // TX engine: each bit held for SB_TICK ticks, line idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= ST_IDLE;
         tx_s_r     <= '0;
         tx_n_r     <= '0;
         tx_b_r     <= '0;
         tx_pen_r   <= 1'b0;
         tx_par_r   <= 1'b0;
         tx_r       <= 1'b1;
      end else begin
         case (tx_state_r)
            ST_IDLE: begin
               if (!tx_empty_s) begin
                  tx_state_r <= ST_START;
                  tx_s_r     <= '0;
                  tx_b_r     <= tx_head_s;
                  tx_pen_r   <= parity_en;
                  tx_par_r   <= parity_bit(9'(tx_head_s), parity_odd);
                  tx_r       <= 1'b0;
               end else begin
                  tx_r <= 1'b1;
               end
            end
            ST_START: begin
               if (tick_r) begin
                  if (tx_s_r == S_LAST) begin
                     tx_s_r     <= '0;
                     tx_n_r     <= '0;
                     tx_r       <= tx_b_r[0];
                     tx_state_r <= ST_DATA;
                  end else begin
                     tx_s_r <= tx_s_r + S_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick_r) begin
                  if (tx_s_r == S_LAST) begin
                     tx_s_r <= '0;
                     tx_b_r <= {1'b0, tx_b_r[DBIT-1:1]};
                     if (tx_n_r == N_LAST) begin
                        tx_state_r <= tx_pen_r ? ST_PARITY : ST_STOP;
                        tx_r       <= tx_pen_r ? tx_par_r : 1'b1;
                     end else begin
                        tx_n_r <= tx_n_r + N_W'(1);
                        tx_r   <= tx_b_r[1];
                     end
                  end else begin
                     tx_s_r <= tx_s_r + S_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick_r) begin
                  if (tx_s_r == S_LAST) begin
                     tx_s_r     <= '0;
                     tx_r       <= 1'b1;
                     tx_state_r <= ST_STOP;
                  end else begin
                     tx_s_r <= tx_s_r + S_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick_r) begin
                  if (tx_s_r == S_LAST) begin
                     tx_s_r     <= '0;
                     tx_state_r <= ST_IDLE;
                  end else begin
                     tx_s_r <= tx_s_r + S_W'(1);
                  end
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               tx_r       <= 1'b1;
            end
         endcase
      end
   end

   uart_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (bus.wr_uart),
      .rd     (tx_pop_s),
      .w_data (bus.w_data),
      .r_data (tx_head_s),
      .full   (tx_full_s),
      .empty  (tx_empty_s)
   );

   uart_fifo #(.B(RXW), .W(FIFO_W)) u_rx_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (rx_done_s),
      .rd     (bus.rd_uart),
      .w_data (rx_word_s),
      .r_data (rx_head_s),
      .full   (rx_full_s),
      .empty  (rx_empty_s)
   );

   assign tx           = tx_r;
   assign tick         = tick_r;
   assign bus.tx_full  = tx_full_s;
   assign bus.rx_empty = rx_empty_s;
   assign bus.r_data   = rx_head_s[DBIT-1:0];
   assign bus.rx_ferr  = rx_head_s[DBIT + ERR_FERR_OFS];
   assign bus.rx_perr  = rx_head_s[DBIT + ERR_PERR_OFS];
   assign bus.rx_ovr   = rx_ovr_r;

endmodule
